// File: rtl/alu_seq_muldiv.sv
// Iterative 32-bit unsigned multiply (low word) and divide/remainder sequencer.
// Drives the shared execute-stage ALU one SUM/DIF operation per cycle while busy.
module alu_seq_muldiv #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_result,
   output logic [WIDTH-1:0] o_remainder,
   output logic [WIDTH-1:0] o_alu_op1,
   output logic [WIDTH-1:0] o_alu_op2,
   output logic [2:0]       o_alu_control,
   input  logic [WIDTH-1:0] i_alu_result,
   input  logic [3:0]       i_alu_flags
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

   state_e           r_state;
   logic [CW-1:0]    r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] r_remainder;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_b;

   logic             w_last;
   logic             w_carry;
   logic [WIDTH-1:0] w_rs;
   logic [WIDTH-1:0] w_acc_next;
   logic [WIDTH-1:0] w_rem_next;
   logic [WIDTH-1:0] w_q_next;
   logic             w_unused_flags;

   // Only the carry (no-borrow) flag steers the restoring divide.
   assign w_carry        = i_alu_flags[1];
   assign w_unused_flags = ^{i_alu_flags[3:2], i_alu_flags[0]};

   assign w_last     = (r_cnt == CW'(WIDTH - 1));
   assign w_rs       = {r_rem[WIDTH-2:0], r_q[WIDTH-1]};
   assign w_acc_next = r_mplier[0] ? i_alu_result : r_acc;
   assign w_rem_next = w_carry ? i_alu_result : w_rs;
   assign w_q_next   = {r_q[WIDTH-2:0], w_carry};

   always_comb begin
      o_alu_op1     = '0;
      o_alu_op2     = '0;
      o_alu_control = 3'b000;
      unique case (r_state)
         StMul: begin
            o_alu_op1 = r_acc;
            o_alu_op2 = r_mcand;
         end
         StDiv: begin
            o_alu_op1     = w_rs;
            o_alu_op2     = r_b;
            o_alu_control = 3'b001;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_cnt       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_result    <= '0;
         r_remainder <= '0;
         r_acc       <= '0;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_rem       <= '0;
         r_q         <= '0;
         r_b         <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (i_start) begin
                  r_acc    <= '0;
                  r_mcand  <= i_a;
                  r_mplier <= i_b;
                  r_rem    <= '0;
                  r_q      <= i_a;
                  r_b      <= i_b;
                  r_cnt    <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= i_op ? StDiv : StMul;
               end
            end
            StMul: begin
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + CW'(1);
               if (w_last) begin
                  r_result    <= w_acc_next;
                  r_remainder <= '0;
                  r_done      <= 1'b1;
                  r_state     <= StDone;
               end
            end
            StDiv: begin
               r_rem <= w_rem_next;
               r_q   <= w_q_next;
               r_cnt <= r_cnt + CW'(1);
               if (w_last) begin
                  r_result    <= w_q_next;
                  r_remainder <= w_rem_next;
                  r_done      <= 1'b1;
                  r_state     <= StDone;
               end
            end
            default: begin
               // DONE always returns to IDLE; a start here is dropped.
               r_busy  <= 1'b0;
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_result    = r_result;
   assign o_remainder = r_remainder;

endmodule
